float_div_seq: RTL

- Multi-cycle IEEE-754 single-precision divider (out = a / b), the inverse companion of the float multiplier in the float unit.
- Uses the same req/ack handshake as the other float units.
- FSM unpacks the operands, runs a 1-bit-per-cycle restoring mantissa divider sub-module, normalises, clamps the exponent and packs the result.
- Latency is fixed for all operand classes.

---
 rtl/float_pkg.sv | 41 ++++
 rtl/float_div_seq_if.sv | 32 +++
 rtl/mant_div_restoring_24bit.sv | 98 +++++++++
 rtl/float_div_seq.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/float_pkg.sv
// Shared float-unit definitions: IEEE-754 single-precision field widths, bias,
// the canonical quiet NaN, the operand class enum (also used by the multiplier)
// and the divider sequencer state encoding.
package float_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MANT_W = 23;
  localparam int          BIAS   = 127;
  localparam logic [31:0] QNAN   = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ZERO,
    NORM,
    INF,
    NAN
  } float_class_e;

  typedef enum logic [2:0] {
    StIdle,
    StUnpack,
    StDivide,
    StNormalize,
    StSetExp,
    StPack
  } div_state_e;

  // Denormals (exp == 0) are flushed and therefore classed as zero.
  function automatic float_class_e classify(input logic [EXP_W-1:0]  exp_f,
                                            input logic [MANT_W-1:0] mant_f);
    float_class_e cls;
    if (exp_f == '0) begin
      cls = ZERO;
    end else if (exp_f == '1) begin
      cls = (mant_f != '0) ? NAN : INF;
    end else begin
      cls = NORM;
    end
    return cls;
  endfunction

endpackage

// File: rtl/float_div_seq_if.sv
// Request/acknowledge bus of the sequential float divider.
//   req : start request (master -> slave), sampled only while the divider is idle
//   a,b : dividend / divisor (master -> slave), captured when req is accepted
//   ack : one-cycle pulse (slave -> master), out valid
//   out : quotient (slave -> master), held until the next ack
interface float_div_seq_if #(
  parameter int unsigned float_width = 32
) ();

  logic                   req;
  logic                   ack;
  logic [float_width-1:0] a;
  logic [float_width-1:0] b;
  logic [float_width-1:0] out;

  modport master (
    output req,
    output a,
    output b,
    input  ack,
    input  out
  );

  modport slave (
    input  req,
    input  a,
    input  b,
    output ack,
    output out
  );

endinterface

// File: rtl/mant_div_restoring_24bit.sv
// Restoring shift-subtract mantissa divider, one quotient bit per cycle.
// Computes quotient = floor((a << 25) / b) (26 bits) and the final remainder.
// Ports:
//   clk, rst  : clock, synchronous active-low reset (aborts a running division)
//   start     : 1-cycle pulse, a and b sampled on that edge
//   a, b      : 24-bit mantissas including the hidden bit
//   quotient  : 26-bit quotient, valid with done
//   remainder : final remainder, valid with done
//   done      : 1-cycle pulse, 26 cycles after start
module mant_div_restoring_24bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [23:0] a,
  input  logic [23:0] b,
  output logic [25:0] quotient,
  output logic [24:0] remainder,
  output logic        done
);

  logic [24:0] w_q, w_d;      // partial remainder, already shifted for the next compare
  logic [24:0] rem_q, rem_d;
  logic [23:0] b_q, b_d;
  logic [25:0] q_q, q_d;
  logic [4:0]  cnt_q, cnt_d;  // iterations still to run after the current one
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [24:0] cur;
  logic [23:0] dvs;
  logic [24:0] sub;
  logic [24:0] nrem;
  logic        ge;
  logic [25:0] nq;

  // The first quotient bit is produced on the start edge itself, straight from the
  // inputs, so the 26th bit lands 25 edges later.
  always_comb begin
    cur  = start ? {1'b0, a} : w_q;
    dvs  = start ? b : b_q;
    ge   = (cur >= {1'b0, dvs});
    sub  = cur - {1'b0, dvs};
    nrem = ge ? sub : cur;
    nq   = start ? {25'd0, ge} : {q_q[24:0], ge};
  end

  always_comb begin
    w_d    = w_q;
    rem_d  = rem_q;
    b_d    = b_q;
    q_d    = q_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start) begin
      w_d    = {nrem[23:0], 1'b0};
      rem_d  = nrem;
      b_d    = b;
      q_d    = nq;
      cnt_d  = 5'd25;
      busy_d = 1'b1;
    end else if (busy_q) begin
      w_d   = {nrem[23:0], 1'b0};
      rem_d = nrem;
      q_d   = nq;
      cnt_d = cnt_q - 5'd1;
      if (cnt_q == 5'd1) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      w_q    <= '0;
      rem_q  <= '0;
      b_q    <= '0;
      q_q    <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      w_q    <= w_d;
      rem_q  <= rem_d;
      b_q    <= b_d;
      q_q    <= q_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign quotient  = q_q;
  assign remainder = rem_q;
  assign done      = done_q;

endmodule

// File: rtl/float_div_seq.sv
// Multi-cycle IEEE-754 single-precision divider, out = a / b.
// Fixed latency: ack rises 30 edges after the edge that accepted req, for every
// operand class. Denormals are flushed to zero.
// Ports:
//   clk : clock
//   rst : synchronous active-low reset, aborts a running operation
//   bus : float_div_seq_if slave (req, a, b in; ack, out out)
// Build option: define FLOAT_DIV_ROUND_EN for round-to-nearest-even; otherwise the
// quotient mantissa is truncated.
module float_div_seq
  import float_pkg::*;
#(
  parameter int unsigned float_width = 32  // only 32 is supported
) (
  input logic            clk,
  input logic            rst,
  float_div_seq_if.slave bus
);

  div_state_e             state_q, state_d;
  logic [float_width-1:0] a_q, a_d;
  logic [float_width-1:0] b_q, b_d;
  logic                   sign_q, sign_d;
  logic signed [9:0]      exp_q, exp_d;
  float_class_e           cls_a_q, cls_a_d;
  float_class_e           cls_b_q, cls_b_d;
  logic [MANT_W-1:0]      mant_q, mant_d;
  logic                   guard_q, guard_d;
  logic                   sticky_q, sticky_d;
  logic [float_width-1:0] res_q, res_d;
  logic [float_width-1:0] out_q, out_d;
  logic                   ack_q, ack_d;

  // Operand fields of the captured request.
  logic [EXP_W-1:0]  ea, eb;
  logic [MANT_W-1:0] fa, fb;
  logic [23:0]       ma, mb;

  assign ea = a_q[MANT_W +: EXP_W];
  assign eb = b_q[MANT_W +: EXP_W];
  assign fa = a_q[MANT_W-1:0];
  assign fb = b_q[MANT_W-1:0];
  assign ma = {(ea != '0), fa};
  assign mb = {(eb != '0), fb};

  logic        div_start;
  logic [25:0] div_quo;
  logic [24:0] div_rem;
  logic        div_done;

  assign div_start = (state_q == StUnpack);

  mant_div_restoring_24bit u_mant_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .a         (ma),
    .b         (mb),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  // Rounding, exponent clamp and special-case substitution.
  logic [MANT_W-1:0]      mant_r;
  logic signed [9:0]      exp_r;
  logic [float_width-1:0] final_res;
  logic                   any_nan, res_inf, res_zero;

`ifdef FLOAT_DIV_ROUND_EN
  logic mant_carry;
`else
  logic unused_round_bits;
  assign unused_round_bits = guard_q ^ sticky_q;
`endif

  always_comb begin
    mant_r = mant_q;
    exp_r  = exp_q;
`ifdef FLOAT_DIV_ROUND_EN
    mant_carry = 1'b0;
    if (guard_q && (sticky_q || mant_q[0])) begin
      {mant_carry, mant_r} = {1'b0, mant_q} + 24'd1;
      // Carry-out means 1.111..1 rounded up to 2.0: mantissa already wrapped to 0.
      if (mant_carry) begin
        exp_r = exp_q + 10'sd1;
      end
    end
`endif
    any_nan  = (cls_a_q == NAN) || (cls_b_q == NAN) ||
               ((cls_a_q == ZERO) && (cls_b_q == ZERO)) ||
               ((cls_a_q == INF) && (cls_b_q == INF));
    res_inf  = (cls_a_q == INF) || (cls_b_q == ZERO);
    res_zero = (cls_a_q == ZERO) || (cls_b_q == INF);
    if (any_nan) begin
      final_res = QNAN;
    end else if (res_inf) begin
      final_res = {sign_q, 8'hFF, 23'd0};
    end else if (res_zero) begin
      final_res = {sign_q, 31'd0};
    end else if (exp_r <= 10'sd0) begin
      final_res = {sign_q, 31'd0};
    end else if (exp_r >= 10'sd255) begin
      final_res = {sign_q, 8'hFF, 23'd0};
    end else begin
      final_res = {sign_q, exp_r[7:0], mant_r};
    end
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    cls_a_d  = cls_a_q;
    cls_b_d  = cls_b_q;
    mant_d   = mant_q;
    guard_d  = guard_q;
    sticky_d = sticky_q;
    res_d    = res_q;
    out_d    = out_q;
    ack_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req) begin
          a_d     = bus.a;
          b_d     = bus.b;
          state_d = StUnpack;
        end
      end
      StUnpack: begin
        sign_d  = a_q[float_width-1] ^ b_q[float_width-1];
        exp_d   = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'(BIAS);
        cls_a_d = classify(ea, fa);
        cls_b_d = classify(eb, fb);
        state_d = StDivide;
      end
      StDivide: begin
        if (div_done) begin
          state_d = StNormalize;
        end
      end
      StNormalize: begin
        // Quotient lies in (2^24, 2^26): bit 25 tells whether it is >= 1.0.
        if (div_quo[25]) begin
          mant_d   = div_quo[24:2];
          guard_d  = div_quo[1];
          sticky_d = div_quo[0] | (div_rem != '0);
        end else begin
          mant_d   = div_quo[23:1];
          guard_d  = div_quo[0];
          sticky_d = (div_rem != '0);
          exp_d    = exp_q - 10'sd1;
        end
        state_d = StSetExp;
      end
      StSetExp: begin
        res_d   = final_res;
        state_d = StPack;
      end
      StPack: begin
        out_d   = res_q;
        ack_d   = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      cls_a_q  <= ZERO;
      cls_b_q  <= ZERO;
      mant_q   <= '0;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      res_q    <= '0;
      out_q    <= '0;
      ack_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      cls_a_q  <= cls_a_d;
      cls_b_q  <= cls_b_d;
      mant_q   <= mant_d;
      guard_q  <= guard_d;
      sticky_q <= sticky_d;
      res_q    <= res_d;
      out_q    <= out_d;
      ack_q    <= ack_d;
    end
  end

  assign bus.ack = ack_q;
  assign bus.out = out_q;

endmodule
